// File: rtl/fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] PC_INC           = 32'd4;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetchState_t;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] instr;
    } fetchEntry_t;

    // Instruction addresses are always word aligned.
    function automatic logic [XLEN-1:0] alignWord(input logic [XLEN-1:0] a);
        return a & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {addr, instr} skid buffer holding a response that arrived during a stall.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        unload,
    input  logic        clear,
    input  fetchEntry_t dataIn,
    output fetchEntry_t dataOut,
    output logic        full
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dataOut <= '0;
        end else if (load && !clear) begin
            dataOut <= dataIn;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// IF stage: owns the PC, fetches over a req/ack handshake and drives IF/ID.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
`ifdef FETCH_PERF_CNT_EN
    ,
    parameter int unsigned PERF_W = 32
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] pcOut,
    output logic [XLEN-1:0] instruction,
    output logic            valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] perf_fetched,
    output logic [PERF_W-1:0] perf_stall_cycles
`endif
);

    fetchState_t     state;
    fetchState_t     stateNext;
    logic [XLEN-1:0] pcReg;
    logic [XLEN-1:0] discardAddr;
    logic            reqActive;
    logic            takeAck;
    logic            toSkid;
    logic            fromSkid;
    logic            skidFull;
    fetchEntry_t     skidIn;
    fetchEntry_t     skidOut;

    // A request is on the bus in REQ and DISCARD; only a REQ ack carries live data.
    assign reqActive = (state != IDLE);
    assign takeAck   = (state == REQ) && imem_ack && !branch_taken;
    assign toSkid    = takeAck && stall;
    assign fromSkid  = skidFull && !stall && !branch_taken;
    assign skidIn    = '{addr: pcReg, instr: imem_rdata};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= REQ;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        if (branch_taken) begin
            stateNext = (reqActive && !imem_ack) ? DISCARD : REQ;
        end else begin
            case (state)
                IDLE:    if (fromSkid || !skidFull) stateNext = REQ;
                REQ:     if (toSkid) stateNext = IDLE;
                DISCARD: if (imem_ack) stateNext = REQ;
                default: stateNext = REQ;
            endcase
        end
    end

    always_comb begin
        imem_req  = reqActive && !reset;
        imem_addr = (state == DISCARD) ? discardAddr : pcReg;
    end

    // PC and IF/ID register; a redirect overrides stall and any same-cycle ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcReg       <= RESET_PC;
            discardAddr <= RESET_PC;
            pcOut       <= '0;
            instruction <= NOP_INSTR;
            valid       <= 1'b0;
        end else if (branch_taken) begin
            pcReg       <= alignWord(branch_target);
            if (state == REQ) discardAddr <= pcReg;
            instruction <= NOP_INSTR;
            valid       <= 1'b0;
        end else begin
            if (takeAck) pcReg <= pcReg + PC_INC;
            if (!stall) begin
                if (skidFull) begin
                    pcOut       <= skidOut.addr + PC_INC;
                    instruction <= skidOut.instr;
                    valid       <= 1'b1;
                end else if (takeAck) begin
                    pcOut       <= pcReg + PC_INC;
                    instruction <= imem_rdata;
                    valid       <= 1'b1;
                end else begin
                    valid       <= 1'b0;
                end
            end
        end
    end

    fetch_skid_buf u_skid (
        .clk    (clk),
        .reset  (reset),
        .load   (toSkid),
        .unload (fromSkid),
        .clear  (branch_taken),
        .dataIn (skidIn),
        .dataOut(skidOut),
        .full   (skidFull)
    );

`ifdef FETCH_PERF_CNT_EN
    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched      <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (takeAck && (perf_fetched != {PERF_W{1'b1}}))
                perf_fetched <= perf_fetched + PERF_W'(1);
            if (stall && valid && (perf_stall_cycles != {PERF_W{1'b1}}))
                perf_stall_cycles <= perf_stall_cycles + PERF_W'(1);
        end
    end
`endif

endmodule
